// File: rtl/param_burst_cache.sv
// Fully associative instruction cache with tree-PLRU replacement and burst line fill.
// Optional early restart (response as soon as the requested beat arrives): define BURST_CACHE_EARLY_RESTART_EN.
`ifndef INSTR_ADDR_BUS_WIDTH
`define INSTR_ADDR_BUS_WIDTH 32
`endif

module param_burst_cache #(
    parameter int WAYS       = 4,
    parameter int LINE_WORDS = 16,
    parameter int ADDR_W     = `INSTR_ADDR_BUS_WIDTH
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [63:0]       resp_data,
    output logic              fill_req_valid,
    input  logic              fill_req_ready,
    output logic [ADDR_W-1:0] fill_req_addr,
    input  logic              fill_data_valid,
    input  logic [63:0]       fill_data,
    input  logic              flush,
    output logic              busy
);

    localparam int WAY_W  = $clog2(WAYS);
    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = WORD_W + 3;
    localparam int TAG_W  = ADDR_W - OFF_W;
    localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(LINE_WORDS - 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_MISS_REQ = 2'd1;
    localparam logic [1:0] S_FILL     = 2'd2;
    localparam logic [1:0] S_RESP     = 2'd3;

    logic [1:0]        state;
    logic [WAYS-1:0]   valid;
    logic [WAYS-1:1]   plru;
    logic [WORD_W-1:0] beat_cnt;
    logic [TAG_W-1:0]  tag_q;
    logic [WORD_W-1:0] word_q;
    logic [WAY_W-1:0]  victim_q;
    logic              killed;
`ifdef BURST_CACHE_EARLY_RESTART_EN
    logic              resp_done;
`endif

    logic [TAG_W-1:0]  tag_mem  [WAYS];
    logic [63:0]       data_mem [WAYS][LINE_WORDS];

    logic [TAG_W-1:0]  req_tag;
    logic [WORD_W-1:0] req_word;
    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic [WAY_W-1:0]  victim;
    logic              unused_low_bits;

    assign req_tag         = req_addr[ADDR_W-1:OFF_W];
    assign req_word        = req_addr[OFF_W-1:3];
    assign unused_low_bits = ^req_addr[2:0];

    assign req_ready      = (state == S_IDLE) && !flush && !resp_valid;
    assign busy           = (state != S_IDLE);
    assign fill_req_addr  = {tag_q, {OFF_W{1'b0}}};

    // Heap-ordered tree: node n has children 2n and 2n+1; a bit of 1 points toward the right child as the next victim.
    function automatic logic [WAYS-1:1] plru_touch(input logic [WAYS-1:1] cur, input logic [WAY_W-1:0] way);
        logic [WAY_W:0]   node;
        logic [WAYS-1:1]  res;
        res  = cur;
        node = {1'b1, way};
        for (int l = 0; l < WAY_W; l++) begin
            res[node[WAY_W:1]] = ~node[0];
            node = node >> 1;
        end
        return res;
    endfunction

    function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-1:1] cur);
        logic [WAY_W:0] node;
        node = {{WAY_W{1'b0}}, 1'b1};
        for (int l = 0; l < WAY_W; l++) begin
            node = {node[WAY_W-1:0], cur[node[WAY_W-1:0]]};
        end
        return node[WAY_W-1:0];
    endfunction

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[w] && tag_mem[w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Invalid ways are consumed lowest index first before PLRU ever decides.
    always_comb begin
        logic found;
        found  = 1'b0;
        victim = plru_victim(plru);
        for (int w = 0; w < WAYS; w++) begin
            if (!valid[w] && !found) begin
                found  = 1'b1;
                victim = WAY_W'(w);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_FILL && fill_data_valid) begin
            data_mem[victim_q][beat_cnt] <= fill_data;
            if (beat_cnt == LAST_BEAT) begin
                tag_mem[victim_q] <= tag_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= S_IDLE;
            valid          <= '0;
            plru           <= '0;
            beat_cnt       <= '0;
            resp_valid     <= 1'b0;
            fill_req_valid <= 1'b0;
            resp_data      <= '0;
            tag_q          <= '0;
            word_q         <= '0;
            victim_q       <= '0;
            killed         <= 1'b0;
`ifdef BURST_CACHE_EARLY_RESTART_EN
            resp_done      <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (resp_valid && resp_ready) begin
                        resp_valid <= 1'b0;
                    end
                    if (flush) begin
                        valid <= '0;
                        plru  <= '0;
                    end else if (req_valid && req_ready) begin
                        if (hit) begin
                            resp_valid <= 1'b1;
                            resp_data  <= data_mem[hit_way][req_word];
                            plru       <= plru_touch(plru, hit_way);
                        end else begin
                            tag_q          <= req_tag;
                            word_q         <= req_word;
                            victim_q       <= victim;
                            fill_req_valid <= 1'b1;
                            killed         <= 1'b0;
`ifdef BURST_CACHE_EARLY_RESTART_EN
                            resp_done      <= 1'b0;
`endif
                            state          <= S_MISS_REQ;
                        end
                    end
                end
                S_MISS_REQ: begin
                    if (fill_req_ready) begin
                        fill_req_valid  <= 1'b0;
                        valid[victim_q] <= 1'b0;
                        state           <= S_FILL;
                    end
                end
                S_FILL: begin
`ifdef BURST_CACHE_EARLY_RESTART_EN
                    if (resp_valid && resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_done  <= 1'b1;
                    end
`endif
                    if (fill_data_valid) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == word_q) begin
                            resp_data <= fill_data;
`ifdef BURST_CACHE_EARLY_RESTART_EN
                            resp_valid <= 1'b1;
`endif
                        end
                        if (beat_cnt == LAST_BEAT) begin
                            if (!killed && !flush) begin
                                valid[victim_q] <= 1'b1;
                            end
                            plru <= plru_touch(plru, victim_q);
`ifdef BURST_CACHE_EARLY_RESTART_EN
                            if (resp_done || (resp_valid && resp_ready)) begin
                                state <= S_IDLE;
                            end else begin
                                state <= S_RESP;
                            end
`else
                            resp_valid <= 1'b1;
                            state      <= S_RESP;
`endif
                        end
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
            // A flush while a miss is in flight must also keep the incoming line from becoming valid.
            if (flush && state != S_IDLE) begin
                valid  <= '0;
                killed <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_param_burst_cache.sv
// Directed self-checking bench for param_burst_cache (4 ways, 16-word lines, 32-bit addresses).
// Every fill beat i of line L carries data L + i, so word w of line L reads back as L + w.
module tb_param_burst_cache;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic        fill_req_valid;
    logic        fill_req_ready;
    logic [31:0] fill_req_addr;
    logic        fill_data_valid;
    logic [63:0] fill_data;
    logic        flush;
    logic        busy;

    int total  = 0;
    int passed = 0;

    param_burst_cache #(
        .WAYS(4),
        .LINE_WORDS(16),
        .ADDR_W(32)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr(req_addr),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data(resp_data),
        .fill_req_valid(fill_req_valid),
        .fill_req_ready(fill_req_ready),
        .fill_req_addr(fill_req_addr),
        .fill_data_valid(fill_data_valid),
        .fill_data(fill_data),
        .flush(flush),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [31:0] addr);
        int n = 0;
        while (!req_ready && n < 50) begin
            step();
            n++;
        end
        if (!req_ready) begin
            total++;
            $display("[TB] FAIL send_req_timeout: req_ready=%0b after %0d cycles, expected 1", req_ready, n);
        end
        req_valid = 1'b1;
        req_addr  = addr;
        step();
        req_valid = 1'b0;
    endtask

    task automatic serve_fill(input int flush_beat, output bit saw_fill, output logic [31:0] faddr);
        int n = 0;
        saw_fill = 1'b0;
        faddr    = '0;
        while (!resp_valid && !fill_req_valid && n < 8) begin
            step();
            n++;
        end
        if (fill_req_valid) begin
            saw_fill       = 1'b1;
            faddr          = fill_req_addr;
            fill_req_ready = 1'b1;
            step();
            fill_req_ready = 1'b0;
            for (int i = 0; i < 16; i++) begin
                fill_data_valid = 1'b1;
                fill_data       = {32'h0, faddr + 32'(i)};
                flush           = (i == flush_beat);
                step();
            end
            fill_data_valid = 1'b0;
            fill_data       = '0;
            flush           = 1'b0;
        end else if (!resp_valid) begin
            total++;
            $display("[TB] FAIL serve_fill_timeout: neither fill_req_valid nor resp_valid after %0d cycles", n);
        end
    endtask

    task automatic wait_resp(output int waited);
        waited = 0;
        while (!resp_valid && waited < 40) begin
            step();
            waited++;
        end
        if (!resp_valid) begin
            total++;
            $display("[TB] FAIL wait_resp_timeout: resp_valid=%0b after %0d cycles, expected 1", resp_valid, waited);
        end
    endtask

    task automatic take_resp(output logic [63:0] d);
        d          = resp_data;
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
    endtask

    task automatic read(input logic [31:0] addr, input int flush_beat, output logic [63:0] d,
                        output bit saw_fill, output logic [31:0] faddr, output int waited);
        send_req(addr);
        serve_fill(flush_beat, saw_fill, faddr);
        wait_resp(waited);
        take_resp(d);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0; fill_req_ready = 1'b0;
        fill_data_valid = 1'b0; fill_data = '0; flush = 1'b0;
        step(); step(); step();
        total++; if (req_ready !== 1'b1) $display("[TB] FAIL reset_req_ready: got %0b expected 1", req_ready); else passed++;
        total++; if (resp_valid !== 1'b0) $display("[TB] FAIL reset_resp_valid: got %0b expected 0", resp_valid); else passed++;
        total++; if (fill_req_valid !== 1'b0) $display("[TB] FAIL reset_fill_req_valid: got %0b expected 0", fill_req_valid); else passed++;
        total++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %0b expected 0", busy); else passed++;
        total++; if (resp_data !== 64'h0) $display("[TB] FAIL reset_resp_data: got %h expected 0", resp_data); else passed++;
        rstn = 1'b1;
        step();
    endtask

    task automatic test_miss_fill();
        bit saw; logic [31:0] fa; int w; logic [63:0] d;
        send_req(32'h1000);
        total++; if (fill_req_valid !== 1'b1) $display("[TB] FAIL miss_fill_req_valid: got %0b expected 1", fill_req_valid); else passed++;
        total++; if (fill_req_addr !== 32'h1000) $display("[TB] FAIL miss_fill_req_addr: got %h expected 00001000", fill_req_addr); else passed++;
        total++; if (busy !== 1'b1) $display("[TB] FAIL miss_busy: got %0b expected 1", busy); else passed++;
        step(); step();
        total++; if (fill_req_valid !== 1'b1) $display("[TB] FAIL miss_fill_req_held: got %0b expected 1", fill_req_valid); else passed++;
        total++; if (fill_req_addr !== 32'h1000) $display("[TB] FAIL miss_fill_addr_stable: got %h expected 00001000", fill_req_addr); else passed++;
        serve_fill(-1, saw, fa);
        total++; if (saw !== 1'b1) $display("[TB] FAIL miss_saw_fill: got %0b expected 1", saw); else passed++;
        wait_resp(w);
        total++; if (w !== 0) $display("[TB] FAIL miss_resp_latency: waited %0d cycles after last beat, expected 0", w); else passed++;
        take_resp(d);
        total++; if (d !== 64'h1000) $display("[TB] FAIL miss_resp_data: got %h expected 1000", d); else passed++;
        total++; if (busy !== 1'b0) $display("[TB] FAIL miss_busy_after: got %0b expected 0", busy); else passed++;
    endtask

    task automatic test_hit();
        bit saw; logic [31:0] fa; int w; logic [63:0] d;
        read(32'h1038, -1, d, saw, fa, w);
        total++; if (saw !== 1'b0) $display("[TB] FAIL hit_no_fill: fill seen=%0b expected 0", saw); else passed++;
        total++; if (w !== 0) $display("[TB] FAIL hit_latency: waited %0d extra cycles expected 0", w); else passed++;
        total++; if (d !== 64'h1007) $display("[TB] FAIL hit_data: got %h expected 1007", d); else passed++;
    endtask

    task automatic test_flush_idle();
        bit saw; logic [31:0] fa; int w; logic [63:0] d;
        flush = 1'b1; req_valid = 1'b1; req_addr = 32'h1000;
        #1;
        total++; if (req_ready !== 1'b0) $display("[TB] FAIL flush_req_ready: got %0b expected 0", req_ready); else passed++;
        step();
        flush = 1'b0; req_valid = 1'b0;
        total++; if (resp_valid !== 1'b0) $display("[TB] FAIL flush_wins_resp: got %0b expected 0", resp_valid); else passed++;
        read(32'h1000, -1, d, saw, fa, w);
        total++; if (saw !== 1'b1) $display("[TB] FAIL flush_idle_remiss: fill seen=%0b expected 1", saw); else passed++;
        total++; if (d !== 64'h1000) $display("[TB] FAIL flush_idle_data: got %h expected 1000", d); else passed++;
    endtask

    task automatic test_plru();
        bit saw; logic [31:0] fa; int w; logic [63:0] d;
        logic [31:0] lines [4];
        lines = '{32'h0000, 32'h0080, 32'h0100, 32'h0180};
        flush = 1'b1; step(); flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            read(lines[i], -1, d, saw, fa, w);
            total++; if (saw !== 1'b1) $display("[TB] FAIL plru_fill_%0d: fill seen=%0b expected 1", i, saw); else passed++;
        end
        read(32'h0000, -1, d, saw, fa, w);
        total++; if (saw !== 1'b0) $display("[TB] FAIL plru_touch0: fill seen=%0b expected 0", saw); else passed++;
        read(32'h0208, -1, d, saw, fa, w);
        total++; if (fa !== 32'h0200) $display("[TB] FAIL plru_new_fill_addr: got %h expected 00000200", fa); else passed++;
        total++; if (d !== 64'h0201) $display("[TB] FAIL plru_new_data: got %h expected 201", d); else passed++;
        read(32'h0088, -1, d, saw, fa, w);
        total++; if (saw !== 1'b0) $display("[TB] FAIL plru_0080_hit: fill seen=%0b expected 0", saw); else passed++;
        total++; if (d !== 64'h0081) $display("[TB] FAIL plru_0080_data: got %h expected 81", d); else passed++;
        read(32'h0000, -1, d, saw, fa, w);
        total++; if (saw !== 1'b0) $display("[TB] FAIL plru_0000_hit: fill seen=%0b expected 0", saw); else passed++;
        read(32'h0180, -1, d, saw, fa, w);
        total++; if (saw !== 1'b0) $display("[TB] FAIL plru_0180_hit: fill seen=%0b expected 0", saw); else passed++;
        read(32'h0100, -1, d, saw, fa, w);
        total++; if (saw !== 1'b1) $display("[TB] FAIL plru_0100_evicted: fill seen=%0b expected 1", saw); else passed++;
    endtask

    task automatic test_flush_mid_fill();
        bit saw; logic [31:0] fa; int w; logic [63:0] d;
        read(32'h2000, 5, d, saw, fa, w);
        total++; if (d !== 64'h2000) $display("[TB] FAIL midflush_resp_data: got %h expected 2000", d); else passed++;
        read(32'h2000, -1, d, saw, fa, w);
        total++; if (saw !== 1'b1) $display("[TB] FAIL midflush_remiss: fill seen=%0b expected 1", saw); else passed++;
        total++; if (d !== 64'h2000) $display("[TB] FAIL midflush_refill_data: got %h expected 2000", d); else passed++;
        read(32'h0000, -1, d, saw, fa, w);
        total++; if (saw !== 1'b1) $display("[TB] FAIL midflush_old_line: fill seen=%0b expected 1", saw); else passed++;
    endtask

    task automatic test_backpressure();
        logic [63:0] d;
        send_req(32'h2008);
        for (int i = 0; i < 10; i++) begin
            total++; if (resp_valid !== 1'b1) $display("[TB] FAIL hold_resp_valid_%0d: got %0b expected 1", i, resp_valid); else passed++;
            total++; if (resp_data !== 64'h2001) $display("[TB] FAIL hold_resp_data_%0d: got %h expected 2001", i, resp_data); else passed++;
            total++; if (req_ready !== 1'b0) $display("[TB] FAIL hold_req_ready_%0d: got %0b expected 0", i, req_ready); else passed++;
            step();
        end
        take_resp(d);
        total++; if (d !== 64'h2001) $display("[TB] FAIL hold_final_data: got %h expected 2001", d); else passed++;
        total++; if (req_ready !== 1'b1) $display("[TB] FAIL hold_release_ready: got %0b expected 1", req_ready); else passed++;
    endtask

    task automatic test_back_to_back();
        bit saw; logic [31:0] fa; int w; logic [63:0] d;
        read(32'h2010, -1, d, saw, fa, w);
        total++; if (d !== 64'h2002 || saw !== 1'b0) $display("[TB] FAIL b2b_first: data %h fill %0b expected 2002 fill 0", d, saw); else passed++;
        read(32'h2018, -1, d, saw, fa, w);
        total++; if (d !== 64'h2003 || saw !== 1'b0) $display("[TB] FAIL b2b_second: data %h fill %0b expected 2003 fill 0", d, saw); else passed++;
    endtask

    task automatic test_response_timing();
        send_req(32'h3018);
        fill_req_ready = 1'b1; step(); fill_req_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            fill_data_valid = 1'b1;
            fill_data       = {32'h0, 32'h3000 + 32'(i)};
`ifdef BURST_CACHE_EARLY_RESTART_EN
            resp_ready      = (i == 5);
`endif
            step();
            if (i == 2) begin
                total++; if (resp_valid !== 1'b0) $display("[TB] FAIL timing_beat2_resp: got %0b expected 0", resp_valid); else passed++;
            end
`ifdef BURST_CACHE_EARLY_RESTART_EN
            if (i == 3) begin
                total++; if (resp_valid !== 1'b1) $display("[TB] FAIL early_beat3_resp: got %0b expected 1", resp_valid); else passed++;
                total++; if (resp_data !== 64'h3003) $display("[TB] FAIL early_beat3_data: got %h expected 3003", resp_data); else passed++;
            end
            if (i == 14) begin
                total++; if (busy !== 1'b1) $display("[TB] FAIL early_busy_beat14: got %0b expected 1", busy); else passed++;
            end
            if (i == 15) begin
                total++; if (busy !== 1'b0) $display("[TB] FAIL early_idle_after_last: got %0b expected 0", busy); else passed++;
            end
`else
            if (i == 3) begin
                total++; if (resp_valid !== 1'b0) $display("[TB] FAIL timing_beat3_resp: got %0b expected 0", resp_valid); else passed++;
            end
            if (i == 15) begin
                total++; if (resp_valid !== 1'b1) $display("[TB] FAIL timing_last_resp: got %0b expected 1", resp_valid); else passed++;
                total++; if (resp_data !== 64'h3003) $display("[TB] FAIL timing_last_data: got %h expected 3003", resp_data); else passed++;
            end
`endif
        end
        fill_data_valid = 1'b0;
        resp_ready      = 1'b0;
`ifndef BURST_CACHE_EARLY_RESTART_EN
        resp_ready = 1'b1; step(); resp_ready = 1'b0;
        total++; if (busy !== 1'b0) $display("[TB] FAIL timing_idle_after_resp: got %0b expected 0", busy); else passed++;
`endif
    endtask

    task automatic test_reset_mid_burst();
        bit saw; logic [31:0] fa; int w; logic [63:0] d;
        send_req(32'h5000);
        fill_req_ready = 1'b1; step(); fill_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fill_data_valid = 1'b1; fill_data = {32'h0, 32'h5000 + 32'(i)}; step();
        end
        rstn = 1'b0;
        #1;
        total++; if (busy !== 1'b0) $display("[TB] FAIL rst_mid_busy: got %0b expected 0", busy); else passed++;
        total++; if (resp_valid !== 1'b0) $display("[TB] FAIL rst_mid_resp_valid: got %0b expected 0", resp_valid); else passed++;
        step();
        rstn = 1'b1;
        for (int i = 3; i < 16; i++) begin
            fill_data_valid = 1'b1; fill_data = {32'h0, 32'h5000 + 32'(i)}; step();
        end
        fill_data_valid = 1'b0;
        total++; if (busy !== 1'b0) $display("[TB] FAIL rst_beats_ignored_busy: got %0b expected 0", busy); else passed++;
        total++; if (resp_valid !== 1'b0) $display("[TB] FAIL rst_beats_ignored_resp: got %0b expected 0", resp_valid); else passed++;
        total++; if (fill_req_valid !== 1'b0) $display("[TB] FAIL rst_fill_req_valid: got %0b expected 0", fill_req_valid); else passed++;
        read(32'h2000, -1, d, saw, fa, w);
        total++; if (saw !== 1'b1) $display("[TB] FAIL rst_valid_cleared: fill seen=%0b expected 1", saw); else passed++;
        total++; if (d !== 64'h2000) $display("[TB] FAIL rst_refill_data: got %h expected 2000", d); else passed++;
    endtask

    initial begin
        test_reset();
        test_miss_fill();
        test_hit();
        test_flush_idle();
        test_plru();
        test_flush_mid_fill();
        test_backpressure();
        test_back_to_back();
        test_response_timing();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/param_burst_cache.md
PARAM_BURST_CACHE -- requirements
Module: param_burst_cache

Interface
REQ-001 SHALL have parameters: WAYS, default 4, way count, power of 2 in 2..8; LINE_WORDS, default 16, 64-bit words per line, power of 2 in 4..32; ADDR_W, default `INSTR_ADDR_BUS_WIDTH, address width.
REQ-002 SHALL use one clock; reset is asynchronous and active-low; ports clk, rstn.
REQ-003 clk  in  1  clock.
REQ-004 rstn  in  1  asynchronous active-low reset.
REQ-005 req_valid / req_ready  in / out  1 / 1  lookup handshake.
REQ-006 req_addr  in  ADDR_W  byte address; word index = addr[3+log2(LINE_WORDS)-1:3].
REQ-007 resp_valid / resp_ready  out / in  1 / 1  response handshake.
REQ-008 resp_data  out  64  requested word.
REQ-009 fill_req_valid / fill_req_ready  out / in  1 / 1  burst request handshake.
REQ-010 fill_req_addr  out  ADDR_W  line-aligned address, low 3+log2(LINE_WORDS) bits zero.
REQ-011 fill_data_valid  in  1  burst beat valid, beats arrive word 0 first.
REQ-012 fill_data  in  64  burst beat data.
REQ-013 flush  in  1  invalidate all lines.
REQ-014 busy  out  1  high in any state other than IDLE.

Function
REQ-015 SHALL be fully associative: WAYS lines, each with tag = addr[ADDR_W-1:3+log2(LINE_WORDS)] and a valid bit; hit = valid and tag equal; at most one way hits.
REQ-016 SHALL implement FSM IDLE, MISS_REQ, FILL, RESP; req_ready = 1 only in IDLE with flush low.
REQ-017 Hit on accept: stay IDLE, register word; resp_valid asserts the next cycle; PLRU updated toward the hit way.
REQ-018 Miss on accept: latch address, choose victim, go MISS_REQ; fill_req_valid held high with stable fill_req_addr until fill_req_ready, then FILL.
REQ-019 Victim: lowest-index invalid way if any, else way pointed to by tree-PLRU (WAYS-1 bits); the victim's valid bit clears on entry to FILL.
REQ-020 FILL: each fill_data_valid beat writes the victim at beat counter, counter increments; after beat LINE_WORDS-1 write tag, set valid, update PLRU to the victim, go RESP; counter then wraps to 0.
REQ-021 RESP: resp_valid = 1 with requested word; on resp_ready go IDLE.
REQ-022 resp_valid, once high, SHALL hold with stable resp_data until resp_ready; no new request accepted meanwhile.
REQ-023 Flush in IDLE: all valid bits clear next edge, PLRU reset to 0; flush wins over a simultaneous req_valid.
REQ-024 Flush during MISS_REQ/FILL/RESP: clear all valid bits; the burst completes; the filled line SHALL NOT be marked valid; the pending response is still delivered.
REQ-025 Miss-to-response latency without the option: handshake cycles + LINE_WORDS beats + 1 cycle.

Reset
REQ-026 On rstn low, asynchronously: state IDLE, valid bits 0, PLRU 0, beat counter 0, resp_valid 0, fill_req_valid 0, resp_data 0, busy 0; tag/data arrays not reset.
REQ-027 Reset mid-burst SHALL abandon the fill; remaining beats after reset release are ignored in IDLE.

Configuration
REQ-028 Macro BURST_CACHE_EARLY_RESTART_EN defined: in FILL, resp_valid asserts on the cycle after the beat whose index equals the requested word index, while filling continues; FSM enters IDLE only when both the last beat and resp_ready have been seen.
REQ-029 Macro undefined: response only from RESP per REQ-021.

Verification
REQ-030 Reset, req 0x1000 -> miss, fill_req_addr 0x1000, 16 beats 0x1000+i; resp_data = 0x1000 at resp_valid.
REQ-031 Re-read 0x1038 -> hit, resp_valid next cycle, resp_data 0x1007, no fill_req_valid.
REQ-032 Fill lines 0x0000,0x0080,0x0100,0x0180, touch 0x0000, miss 0x0200 -> victim way 2 (tree-PLRU), 0x0080 still hits.
REQ-033 Flush asserted on beat 5 of fill 0x2000 -> response delivered, later read 0x2000 misses again.
REQ-034 resp_ready held low 10 cycles -> resp_valid and resp_data stable, req_ready 0.
REQ-035 With BURST_CACHE_EARLY_RESTART_EN, miss 0x3018 -> resp_valid on the cycle after beat 3, busy until beat 15.
